// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR read-modify-write, 64-bit cycle/instret counters and tohost channel
module csr_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_wen,
    input  logic [2:0]  csr_sel,
    input  logic [2:0]  funct3,
    input  logic [11:0] csr_addr,
    input  logic [31:0] rs1_data,
    input  logic [4:0]  zimm,
    input  logic        stall,
    input  logic        inst_retire,
    output logic [31:0] csr_rdata,
    output logic [31:0] tohost,
    output logic        tohost_valid,
    output logic        illegal_csr
);
    logic [31:0] mscratch, src, old, upd;
    logic [63:0] cycle, instret;
    logic        known, ro, do_write, wr, wr_tohost, unused;
    assign unused = funct3[2];
    assign src = (csr_sel == 3'b001) ? {27'b0, zimm} : rs1_data;
    assign ro = csr_addr == 12'hC00 || csr_addr == 12'hC80 || csr_addr == 12'hC02 || csr_addr == 12'hC82;
    assign known = ro || csr_addr == 12'h51E || csr_addr == 12'h340;
    assign old = csr_addr == 12'h51E ? tohost :
                 csr_addr == 12'h340 ? mscratch :
                 csr_addr == 12'hC00 ? cycle[31:0] :
                 csr_addr == 12'hC80 ? cycle[63:32] :
                 csr_addr == 12'hC02 ? instret[31:0] :
                 csr_addr == 12'hC82 ? instret[63:32] : 32'd0;
    assign upd = funct3[1:0] == 2'b01 ? src :
                 funct3[1:0] == 2'b10 ? (old | src) : (old & ~src);
    // set/clear with a zero operand is a pure read, so it never faults on read-only CSRs
    assign do_write = csr_wen && !stall && funct3[1:0] != 2'b00 && (funct3[1:0] == 2'b01 || src != 32'd0);
    assign wr = do_write && known && !ro;
    assign wr_tohost = wr && csr_addr == 12'h51E;
    assign csr_rdata = csr_wen ? old : 32'd0;
    assign illegal_csr = csr_wen && (!known || (do_write && ro));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle        <= 64'd0;
            instret      <= 64'd0;
            mscratch     <= 32'd0;
            tohost       <= 32'd0;
            tohost_valid <= 1'b0;
        end else begin
            cycle        <= cycle + 64'd1;
            instret      <= instret + {63'd0, inst_retire && !stall};
            tohost_valid <= wr_tohost;
            if (wr_tohost) tohost <= upd;
            if (wr && csr_addr == 12'h340) mscratch <= upd;
        end
    end
endmodule
